// File: rtl/bf_result_streamer.sv
// bf_result_streamer
//   Drains the bellmanford Output Memory onto a valid/ready result stream once
//   the core reports completion, or emits a single negative-cycle marker beat
//   when the core reports a negative cycle.
//
// Ports
//   clock     : system clock, rising edge
//   reset     : asynchronous, active-high reset
//   Finish    : core completion level (rising edge starts a drain)
//   NegCycle  : core negative-cycle level (rising edge emits marker beat)
//   OMAR      : OutputMemory read address (registered)
//   OMDR      : OutputMemory read data, combinational from OMAR
//   out_valid : beat valid
//   out_ready : sink accepts beat
//   out_data  : distance value
//   out_index : vertex index of the beat
//   out_inf   : out_data equals INF_VAL (only while out_valid)
//   out_last  : final beat of the transfer
//   out_neg   : beat is the negative-cycle marker
//   busy      : transfer in progress (LOAD, STREAM, NEGB)
//   done      : transfer complete, sticky until reset
//   dbg_state : current FSM state, for observation only
//
// Handshake: a beat transfers on a rising clock edge where out_valid and
// out_ready are both 1. Once out_valid is raised, out_data/out_index/out_last/
// out_neg stay stable until that transfer, except that a negative-cycle abort
// withdraws an in-flight distance beat. out_ready is ignored while out_valid=0.

module bf_result_streamer #(
  parameter int                 ADDR_W  = 13,
  parameter int                 DATA_W  = 16,
  parameter int                 DEPTH   = 8192,
  parameter logic [DATA_W-1:0]  INF_VAL = {DATA_W{1'b1}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Finish,
  input  logic              NegCycle,
  output logic [ADDR_W-1:0] OMAR,
  input  logic [DATA_W-1:0] OMDR,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_inf,
  output logic              out_last,
  output logic              out_neg,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_NEGB   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_finish_q;
  logic                r_neg_q;
  logic                r_armed;
  logic [ADDR_W-1:0]   r_omar;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_index;
  logic                r_last;
  logic                r_valid;
  logic                r_done;

  logic                w_start;
  logic                w_abort;
  logic                w_valid;
  logic                w_hs;
  logic                w_load;
  logic                w_omar_max;
  logic                w_in_flight;

  // finish_q/neg_q are cleared by reset, so a level that is already high when
  // reset releases would look like an edge on the first cycle. r_armed masks
  // that first cycle so only a genuine rising edge starts a transfer.
  assign w_start     = Finish   & ~r_finish_q & r_armed;
  assign w_abort     = NegCycle & ~r_neg_q    & r_armed;

  assign w_valid     = (r_state == S_NEGB) | r_valid;
  assign w_hs        = w_valid & out_ready;
  assign w_omar_max  = (r_omar == LAST_ADDR);
  assign w_in_flight = (r_state == S_LOAD) | (r_state == S_STREAM);

  // Capture a new beat from the memory read port: the single LOAD cycle, or a
  // STREAM handshake that is not the final beat (back-to-back throughput).
  assign w_load = ~w_abort &
                  ((r_state == S_LOAD) |
                   ((r_state == S_STREAM) & w_hs & ~r_last));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_abort)      w_state_nxt = S_NEGB;
        else if (w_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_abort) w_state_nxt = S_NEGB;
        else         w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (w_abort)              w_state_nxt = S_NEGB;
        else if (w_hs && r_last)  w_state_nxt = S_DONE;
      end
      S_NEGB: begin
        if (w_hs) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_finish_q <= 1'b0;
      r_neg_q    <= 1'b0;
      r_armed    <= 1'b0;
      r_omar     <= '0;
      r_data     <= '0;
      r_index    <= '0;
      r_last     <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_finish_q <= Finish;
      r_neg_q    <= NegCycle;
      r_armed    <= 1'b1;

      if ((r_state == S_IDLE) && !w_abort && w_start) begin
        r_omar <= '0;
      end

      if (w_load) begin
        r_data  <= OMDR;
        r_index <= r_omar;
        r_last  <= w_omar_max;
        r_valid <= 1'b1;
        // Saturate at the last address: the final beat never wraps to 0.
        if (!w_omar_max) begin
          r_omar <= r_omar + ADDR_W'(1);
        end
      end

      if ((r_state == S_STREAM) && !w_abort && w_hs && r_last) begin
        r_valid <= 1'b0;
        r_done  <= 1'b1;
      end

      // Abort withdraws whatever distance beat is pending; NEGB drives the
      // marker beat from the output mux instead of the beat registers.
      if (w_in_flight && w_abort) begin
        r_valid <= 1'b0;
      end

      if ((r_state == S_NEGB) && w_hs) begin
        r_done <= 1'b1;
      end
    end
  end

  assign OMAR      = r_omar;
  assign out_valid = w_valid;
  assign out_neg   = (r_state == S_NEGB);
  assign out_data  = (r_state == S_NEGB) ? INF_VAL : r_data;
  assign out_index = (r_state == S_NEGB) ? '0 : r_index;
  assign out_last  = (r_state == S_NEGB) ? 1'b1 : r_last;
  assign out_inf   = w_valid & (out_data == INF_VAL);
  assign busy      = w_in_flight | (r_state == S_NEGB);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bf_result_streamer.sv
// Testbench for bf_result_streamer. Inputs are driven 1 time unit after each
// rising edge; outputs are compared on the falling edge against a queue of
// expected beats derived from the memory contents and the transfer rules.

module tb_bf_result_streamer;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8192;
  localparam logic [15:0] INF = 16'hFFFF;

  // ---------------- clock / reset ----------------
  logic              clock;
  logic              reset;
  logic              Finish;
  logic              NegCycle;
  logic [ADDR_W-1:0] OMAR;
  logic [DATA_W-1:0] OMDR;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_inf;
  logic              out_last;
  logic              out_neg;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  logic [15:0] mem [0:DEPTH-1];
  assign OMDR = mem[OMAR];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  bf_result_streamer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .INF_VAL(INF)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .Finish   (Finish),
    .NegCycle (NegCycle),
    .OMAR     (OMAR),
    .OMDR     (OMDR),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_inf  (out_inf),
    .out_last (out_last),
    .out_neg  (out_neg),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  // Beat encoding: {neg, last, index[12:0], data[15:0]}
  logic [30:0] exp_q[$];
  int n_checks;
  int n_fail;
  int acc;
  int inf_cnt;
  int last_cnt;
  int last_idx;
  int last_data;
  bit rdy_rand;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic clear_stats();
    acc = 0; inf_cnt = 0; last_cnt = 0; last_idx = -1; last_data = -1;
  endtask

  function automatic logic [30:0] mk_beat(input bit neg, input bit last,
                                          input int idx, input logic [15:0] d);
    logic [12:0] i13;
    i13 = 13'(idx);
    return {neg, last, i13, d};
  endfunction

  // Normal transfer: every address in order, last flag only on the final one.
  task automatic push_drain();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(mk_beat(1'b0, (i == DEPTH - 1), i, mem[i]));
    end
  endtask

  task automatic push_neg();
    exp_q.push_back(mk_beat(1'b1, 1'b1, 0, INF));
  endtask

  // ---------------- compare process ----------------
  task automatic compare_loop();
    logic [30:0] head;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("beat_without_expectation", 32'(out_valid), 32'(0));
          end else begin
            head = exp_q[0];
            chk("beat_data",  32'(out_data),  32'(head[15:0]));
            chk("beat_index", 32'(out_index), 32'(head[28:16]));
            chk("beat_last",  32'(out_last),  32'(head[29]));
            chk("beat_neg",   32'(out_neg),   32'(head[30]));
            chk("beat_inf",   32'(out_inf),   32'(head[15:0] == INF));
            if (out_ready) begin
              void'(exp_q.pop_front());
              acc++;
              if (out_inf)  inf_cnt++;
              if (out_last) last_cnt++;
              last_idx  = int'(out_index);
              last_data = int'(out_data);
            end
          end
        end else begin
          chk("inf_while_idle", 32'(out_inf), 32'(0));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset = 1'b1; Finish = 1'b0; NegCycle = 1'b0;
    out_ready = 1'b0; rdy_rand = 1'b0;
    exp_q.delete();
    clear_stats();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_drained(input int budget, output int used);
    used = 0;
    while (!(done && exp_q.size() == 0) && used < budget) begin
      tick();
      used++;
    end
    if (used >= budget) chk("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_accepted(input int n, input int budget);
    int k;
    k = 0;
    while (acc < n && k < budget) begin
      tick();
      k++;
    end
    if (acc < n) chk("accept_timeout", 32'(acc), 32'(n));
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int used;
    n_checks = 0; n_fail = 0;
    clear_stats();
    reset = 1'b1; Finish = 1'b0; NegCycle = 1'b0; out_ready = 1'b0; rdy_rand = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i);
    fork
      compare_loop();
    join_none

    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_busy",  32'(busy),      32'(0));
    chk("rst_done",  32'(done),      32'(0));
    chk("rst_omar",  32'(OMAR),      32'(0));
    chk("rst_data",  32'(out_data),  32'(0));
    chk("rst_index", 32'(out_index), 32'(0));
    chk("rst_last",  32'(out_last),  32'(0));
    chk("rst_neg",   32'(out_neg),   32'(0));

    // Test 1: full drain, memory[i]=i, no backpressure
    do_reset();
    out_ready = 1'b1;
    push_drain();
    Finish = 1'b1;
    tick();
    chk("lat_first_edge_valid", 32'(out_valid), 32'(0));
    chk("lat_first_edge_busy",  32'(busy),      32'(1));
    tick();
    chk("lat_second_edge_valid", 32'(out_valid), 32'(1));
    wait_drained(9000, used);
    chk("t1_throughput_cycles", 32'(used),      32'(8192));
    chk("t1_beats",             32'(acc),       32'(8192));
    chk("t1_last_index",        32'(last_idx),  32'(8191));
    chk("t1_last_data",         32'(last_data), 32'(16'h1FFF));
    chk("t1_last_count",        32'(last_cnt),  32'(1));
    chk("t1_done",              32'(done),      32'(1));
    chk("t1_busy",              32'(busy),      32'(0));
    idle_ticks(10);

    // Test 2: random backpressure, one INF entry at address 5
    do_reset();
    fill_random();
    mem[5] = INF;
    push_drain();
    rdy_rand = 1'b1;
    Finish = 1'b1;
    wait_drained(40000, used);
    chk("t2_beats",   32'(acc),      32'(8192));
    chk("t2_inf_cnt", 32'(inf_cnt),  32'(1));
    chk("t2_last_ix", 32'(last_idx), 32'(8191));
    chk("t2_done",    32'(done),     32'(1));
    idle_ticks(10);

    // Test 3: negative cycle after 100 accepted beats
    do_reset();
    fill_random();
    push_drain();
    rdy_rand = 1'b1;
    Finish = 1'b1;
    wait_accepted(100, 1000);
    rdy_rand = 1'b0;
    out_ready = 1'b0;
    NegCycle = 1'b1;
    tick();
    exp_q.delete();
    push_neg();
    chk("t3_neg_valid", 32'(out_valid), 32'(1));
    chk("t3_neg_flag",  32'(out_neg),   32'(1));
    out_ready = 1'b1;
    wait_drained(50, used);
    chk("t3_beats",     32'(acc),       32'(101));
    chk("t3_last_data", 32'(last_data), 32'(16'hFFFF));
    chk("t3_done",      32'(done),      32'(1));
    chk("t3_busy",      32'(busy),      32'(0));
    idle_ticks(10);

    // Test 4: Finish and NegCycle rise together in IDLE
    do_reset();
    out_ready = 1'b1;
    push_neg();
    Finish = 1'b1;
    NegCycle = 1'b1;
    tick();
    chk("t4_omar_negb", 32'(OMAR), 32'(0));
    wait_drained(20, used);
    chk("t4_beats", 32'(acc),  32'(1));
    chk("t4_omar",  32'(OMAR), 32'(0));
    idle_ticks(10);

    // Test 5: reset at beat 3000 while stalled, then level vs edge, then
    // a fresh drain with extra Finish pulses during STREAM and after DONE.
    do_reset();
    fill_random();
    push_drain();
    rdy_rand = 1'b1;
    Finish = 1'b1;
    wait_accepted(3000, 10000);
    rdy_rand = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_valid", 32'(out_valid), 32'(0));
    chk("t5_async_busy",  32'(busy),      32'(0));
    chk("t5_async_omar",  32'(OMAR),      32'(0));
    chk("t5_async_data",  32'(out_data),  32'(0));
    chk("t5_async_index", 32'(out_index), 32'(0));
    exp_q.delete();
    clear_stats();
    tick();
    tick();
    reset = 1'b0;
    idle_ticks(20);
    chk("t5_level_no_start_busy", 32'(busy), 32'(0));
    chk("t5_level_no_start_done", 32'(done), 32'(0));
    Finish = 1'b0;
    tick();
    push_drain();
    rdy_rand = 1'b1;
    Finish = 1'b1;
    wait_accepted(4000, 10000);
    Finish = 1'b0;
    tick();
    Finish = 1'b1;
    tick();
    wait_drained(40000, used);
    chk("t5_beats",   32'(acc),      32'(8192));
    chk("t5_last_ix", 32'(last_idx), 32'(8191));
    Finish = 1'b0;
    tick();
    Finish = 1'b1;
    idle_ticks(10);
    chk("t5_after_done_beats", 32'(acc),  32'(8192));
    chk("t5_after_done_done",  32'(done), 32'(1));
    chk("t5_after_done_busy",  32'(busy), 32'(0));

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
